// File: rtl/ad9643_capture_top.sv
// ---------------------------------------------------------------------------
// ad9643_capture_top
//
// Capture front end for a 14-bit dual-rail LVDS ADC (AD9643 class).
// Every clock it registers the true/complement data rails and checks that the
// two rails agree. While enabled it pairs consecutive samples into one 32-bit
// AXI4-Stream beat (older sample in the low lane). Control and status are
// exposed through a small AXI4-Lite slave.
//
// Optional feature macro: TEST_PATTERN_EN
//   defined   : a ramp generator can replace ADC data (CTRL bit1).
//   undefined : no ramp logic; CTRL bit1 is forced to 0 and reads 0.
//
// Parameters
//   DATA_WIDTH      ADC sample width (lanes are 16 bits, so <= 16)
//
// Ports
//   s_axi_aclk      sole clock, rising edge
//   s_axi_aresetn   synchronous active-low reset
//   data_in_p/_n    ADC data, true and complement rails
//   s_axi_aw*/w*/b* AXI4-Lite write channels (bresp always OKAY)
//   s_axi_ar*/r*    AXI4-Lite read channels (rresp always OKAY)
//   m_axis_*        packed sample-pair stream
//
// Register map (decoded on addr[3:2])
//   0x0 CTRL        RW  bit0 ENABLE, bit1 TEST_PATTERN, bit2 FORMAT
//   0x4 STATUS      W1C bit0 OVERFLOW, bit1 PAIR_ERR (sticky)
//   0x8 BEAT_COUNT  RO  accepted stream beats, wraps
//   0xC LAST_SAMPLE RO  most recent registered sample, zero-extended
// ---------------------------------------------------------------------------
module ad9643_capture_top #(
  parameter int DATA_WIDTH = 14
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,

  input  logic [DATA_WIDTH-1:0] data_in_p,
  input  logic [DATA_WIDTH-1:0] data_in_n,

  input  logic [31:0]           s_axi_awaddr,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,

  input  logic [31:0]           s_axi_araddr,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,

  output logic [31:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);

  // Register word indices on addr[3:2].
  localparam logic [1:0] REG_CTRL        = 2'd0;
  localparam logic [1:0] REG_STATUS      = 2'd1;
  localparam logic [1:0] REG_BEAT_COUNT  = 2'd2;
  localparam logic [1:0] REG_LAST_SAMPLE = 2'd3;

  // Bits of CTRL that can actually be written. Without the ramp generator the
  // TEST_PATTERN bit is held at zero so software can detect its absence.
`ifdef TEST_PATTERN_EN
  localparam logic [31:0] CTRL_WRITABLE = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] CTRL_WRITABLE = 32'hFFFF_FFFD;
`endif

  // Upper lane bits that are filled with the sign in two's complement format.
  localparam logic [15:0] SIGN_FILL = ~16'((32'd1 << DATA_WIDTH) - 32'd1);

  // Convert a raw offset-binary sample into a 16-bit lane.
  //   fmt = 0 : zero-extend the offset-binary code
  //   fmt = 1 : flip the MSB (offset binary -> two's complement), sign-extend
  function automatic logic [15:0] to_lane(input logic [DATA_WIDTH-1:0] s,
                                          input logic                  fmt);
    logic [DATA_WIDTH-1:0] t;
    logic [15:0]           l;
    t = s;
    if (fmt) begin
      t[DATA_WIDTH-1] = ~s[DATA_WIDTH-1];
    end
    l = 16'(t);
    if (fmt && t[DATA_WIDTH-1]) begin
      l = l | SIGN_FILL;
    end
    return l;
  endfunction

  // -------------------------------------------------------------------------
  // Register file storage
  // -------------------------------------------------------------------------
  logic [31:0]           ctrl_reg;
  logic [31:0]           ctrl_next;
  logic                  overflow_reg;
  logic                  pair_err_reg;
  logic [31:0]           beat_count_reg;

  logic                  ctrl_enable;
  logic                  ctrl_format;
  assign ctrl_enable = ctrl_reg[0];
  assign ctrl_format = ctrl_reg[2];

  // -------------------------------------------------------------------------
  // Input register: both rails captured every cycle. The complement rail
  // resets to all ones so the idle pair is consistent and PAIR_ERR stays
  // clear coming out of reset.
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] p_reg;
  logic [DATA_WIDTH-1:0] n_reg;

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      p_reg <= '0;
      n_reg <= '1;
    end else begin
      p_reg <= data_in_p;
      n_reg <= data_in_n;
    end
  end

  // The p rail is used even when the rails disagree; the mismatch is only
  // flagged.
  logic pair_err_set;
  assign pair_err_set = (n_reg != ~p_reg);

  // -------------------------------------------------------------------------
  // Sample source: ADC data or, optionally, the test ramp
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] sample_cur;

`ifdef TEST_PATTERN_EN
  logic                  ctrl_test_pattern;
  logic [DATA_WIDTH-1:0] ramp_reg;

  assign ctrl_test_pattern = ctrl_reg[1];

  // Ramp sits at zero while the pattern is off, so it always restarts from 0
  // and then advances one code per sample, wrapping naturally.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      ramp_reg <= '0;
    end else if (!ctrl_test_pattern) begin
      ramp_reg <= '0;
    end else begin
      ramp_reg <= ramp_reg + DATA_WIDTH'(1);
    end
  end

  assign sample_cur = ctrl_test_pattern ? ramp_reg : p_reg;
`else
  assign sample_cur = p_reg;
`endif

  // -------------------------------------------------------------------------
  // Pairing stage: phase 0 keeps the older sample, phase 1 forms the beat.
  // Dropping ENABLE resets the phase and abandons any half-built pair.
  // -------------------------------------------------------------------------
  logic                  phase_reg;
  logic [DATA_WIDTH-1:0] older_reg;
  logic [31:0]           pair_reg;
  logic                  pair_valid_reg;
  logic [31:0]           pair_next;
  logic [DATA_WIDTH-1:0] lane_src [2];

  assign lane_src[0] = older_reg;
  assign lane_src[1] = sample_cur;

  // Lane 0 (low half) carries the older sample, lane 1 the newer one.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      assign pair_next[16*gi +: 16] = to_lane(lane_src[gi], ctrl_format);
    end
  endgenerate

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      phase_reg      <= 1'b0;
      older_reg      <= '0;
      pair_reg       <= '0;
      pair_valid_reg <= 1'b0;
    end else begin
      pair_valid_reg <= 1'b0;
      if (!ctrl_enable) begin
        phase_reg <= 1'b0;
      end else if (!phase_reg) begin
        older_reg <= sample_cur;
        phase_reg <= 1'b1;
      end else begin
        pair_reg       <= pair_next;
        pair_valid_reg <= 1'b1;
        phase_reg      <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output register. A new beat may load only into an empty register or one
  // that is being consumed this cycle; otherwise it is lost and OVERFLOW set.
  // Beats arrive every other cycle, so one stalled cycle is always absorbed.
  // -------------------------------------------------------------------------
  logic [31:0] tdata_reg;
  logic        tvalid_reg;
  logic        overflow_set;
  logic        beat_accept;

  assign beat_accept  = tvalid_reg && m_axis_tready;
  assign overflow_set = pair_valid_reg && tvalid_reg && !m_axis_tready;

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      tdata_reg      <= '0;
      tvalid_reg     <= 1'b0;
      beat_count_reg <= '0;
    end else begin
      if (beat_accept) begin
        beat_count_reg <= beat_count_reg + 32'd1;
      end
      if (pair_valid_reg && (!tvalid_reg || m_axis_tready)) begin
        tdata_reg  <= pair_reg;
        tvalid_reg <= 1'b1;
      end else if (m_axis_tready) begin
        tvalid_reg <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tvalid = tvalid_reg;

  // -------------------------------------------------------------------------
  // AXI4-Lite write path. awready/wready are one shared single-cycle pulse,
  // raised only when both address and data are offered and no response is
  // outstanding; the register update happens on the handshake edge.
  // -------------------------------------------------------------------------
  logic        awready_reg;
  logic        bvalid_reg;
  logic        wr_en;
  logic [1:0]  wr_word;
  logic [31:0] wr_mask;
  logic [1:0]  status_clr;

  assign wr_en   = awready_reg && s_axi_awvalid && s_axi_wvalid;
  assign wr_word = s_axi_awaddr[3:2];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_strb
      assign wr_mask[8*gi +: 8] = {8{s_axi_wstrb[gi]}};
    end
  endgenerate

  always_comb begin
    ctrl_next = ctrl_reg;
    if (wr_en && (wr_word == REG_CTRL)) begin
      ctrl_next = (ctrl_reg & ~wr_mask) | (s_axi_wdata & wr_mask & CTRL_WRITABLE);
    end
  end

  // Only the low byte holds STATUS flags, so only wstrb[0] matters here.
  assign status_clr = (wr_en && (wr_word == REG_STATUS) && s_axi_wstrb[0])
                      ? s_axi_wdata[1:0] : 2'b00;

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      awready_reg  <= 1'b0;
      bvalid_reg   <= 1'b0;
      ctrl_reg     <= '0;
      overflow_reg <= 1'b0;
      pair_err_reg <= 1'b0;
    end else begin
      awready_reg <= s_axi_awvalid && s_axi_wvalid && !bvalid_reg && !awready_reg;
      if (wr_en) begin
        bvalid_reg <= 1'b1;
      end else if (s_axi_bready) begin
        bvalid_reg <= 1'b0;
      end
      ctrl_reg <= ctrl_next;
      // A set event in the same cycle as a W1C clear keeps the flag set.
      overflow_reg <= overflow_set | (overflow_reg & ~status_clr[0]);
      pair_err_reg <= pair_err_set | (pair_err_reg & ~status_clr[1]);
    end
  end

  assign s_axi_awready = awready_reg;
  assign s_axi_wready  = awready_reg;
  assign s_axi_bvalid  = bvalid_reg;
  assign s_axi_bresp   = 2'b00;

  // -------------------------------------------------------------------------
  // AXI4-Lite read path. rdata is captured at the address handshake and held
  // until the master takes it.
  // -------------------------------------------------------------------------
  logic        arready_reg;
  logic        rvalid_reg;
  logic [31:0] rdata_reg;
  logic [31:0] rd_mux;
  logic        rd_en;

  assign rd_en = arready_reg && s_axi_arvalid;

  always_comb begin
    rd_mux = '0;
    case (s_axi_araddr[3:2])
      REG_CTRL:        rd_mux = ctrl_reg;
      REG_STATUS:      rd_mux = {30'd0, pair_err_reg, overflow_reg};
      REG_BEAT_COUNT:  rd_mux = beat_count_reg;
      REG_LAST_SAMPLE: rd_mux = 32'(sample_cur);
      default:         rd_mux = '0;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
    end else begin
      arready_reg <= s_axi_arvalid && !rvalid_reg && !arready_reg;
      if (rd_en) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= rd_mux;
      end else if (s_axi_rready) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

  assign s_axi_arready = arready_reg;
  assign s_axi_rvalid  = rvalid_reg;
  assign s_axi_rdata   = rdata_reg;
  assign s_axi_rresp   = 2'b00;

  // Protection bits and address bits outside [3:2] have no effect.
  logic unused_bits;
  assign unused_bits = ^{s_axi_awprot, s_axi_arprot,
                         s_axi_awaddr[31:4], s_axi_awaddr[1:0],
                         s_axi_araddr[31:4], s_axi_araddr[1:0]};

endmodule

// File: tb/tb_ad9643_capture_top.sv
module tb_ad9643_capture_top;
  localparam int DW = 14;

  logic          clk = 1'b0;
  logic          rstn;
  logic [DW-1:0] data_in_p, data_in_n;
  logic [31:0]   s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata, m_axis_tdata;
  logic [2:0]    s_axi_awprot, s_axi_arprot;
  logic [3:0]    s_axi_wstrb;
  logic [1:0]    s_axi_bresp, s_axi_rresp;
  logic          s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic          s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic          s_axi_rvalid, s_axi_rready, m_axis_tvalid, m_axis_tready;

  always #5 clk = ~clk;

  ad9643_capture_top #(.DATA_WIDTH(DW)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rstn),
    .data_in_p(data_in_p), .data_in_n(data_in_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;          // number of rising edges seen
  int          acc = 0;          // model of accepted beats (tvalid & tready)
  logic [DW-1:0] hist [0:255];   // p rail value present at each edge
  bit          chk_stream = 1'b0;
  bit          fmt_model = 1'b0;

  // Reference lane: offset binary either as-is, or re-centred on midscale
  // (two's complement) and wrapped into 16 bits.
  function automatic logic [15:0] lane_m(input logic [DW-1:0] s, input bit fmt);
    int v;
    v = int'(s);
    if (fmt) v = v - (1 << (DW - 1));
    return 16'(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock step. Beats accepted at this edge are counted beforehand; with
  // chk_stream set, every visible beat is compared against the pair of
  // samples that were on the pins three and two edges earlier.
  task automatic tick();
    logic [31:0] e;
    if (m_axis_tvalid && m_axis_tready) acc++;
    @(posedge clk);
    cyc++;
    hist[cyc % 256] = data_in_p;
    #1;
    if (chk_stream && m_axis_tvalid) begin
      e = {lane_m(hist[(cyc - 2) % 256], fmt_model), lane_m(hist[(cyc - 3) % 256], fmt_model)};
      chk("stream_beat", m_axis_tdata, e);
    end
  endtask

  task automatic drive_tick(input logic [DW-1:0] v);
    data_in_p = v;
    data_in_n = ~v;
    tick();
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output int hs_cyc);
    int k;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    k = 0;
    while (!(s_axi_awready && s_axi_wready) && k < 50) begin tick(); k++; end
    chk("aw_w_ready", {31'd0, s_axi_awready && s_axi_wready}, 32'd1);
    tick();
    hs_cyc = cyc;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    k = 0;
    while (!s_axi_bvalid && k < 50) begin tick(); k++; end
    chk("bvalid", {31'd0, s_axi_bvalid}, 32'd1);
    chk("bresp", {30'd0, s_axi_bresp}, 32'd0);
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    $display("WR addr=0x%08h data=0x%08h strb=%b hs_edge=%0d", addr, data, strb, hs_cyc);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    int k;
    logic [31:0] d;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    k = 0;
    while (!s_axi_arready && k < 50) begin tick(); k++; end
    tick();
    s_axi_arvalid = 1'b0;
    k = 0;
    while (!s_axi_rvalid && k < 50) begin tick(); k++; end
    d = s_axi_rdata;
    chk("rresp", {30'd0, s_axi_rresp}, 32'd0);
    chk(tag, d, exp);
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    $display("RD addr=0x%08h data=0x%08h exp=0x%08h", addr, d, exp);
  endtask

  initial begin
    int h, e0, a0, k;
    logic [31:0] held;
    bit fmt_r;

    rstn = 1'b0;
    data_in_p = '0; data_in_n = '1;
    s_axi_awaddr = '0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_araddr = '0;
    s_axi_awprot = '0; s_axi_arprot = '0;
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_bready = 0;
    s_axi_arvalid = 0; s_axi_rready = 0; m_axis_tready = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_handshakes", {27'd0, s_axi_awready, s_axi_wready, s_axi_bvalid,
                           s_axi_arready, s_axi_rvalid}, 32'd0);
    chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("rst_tdata", m_axis_tdata, 32'd0);
    chk("rst_rdata", s_axi_rdata, 32'd0);
    chk("rst_resp", {28'd0, s_axi_bresp, s_axi_rresp}, 32'd0);
    rstn = 1'b1;
    tick();
    rd_chk("ctrl_rst", 32'h0, 32'h0);
    rd_chk("status_rst", 32'h4, 32'h0);
    rd_chk("count_rst", 32'h8, 32'h0);
    chk("tvalid_idle", {31'd0, m_axis_tvalid}, 32'd0);

    // CTRL storage and byte strobes
    axi_write(32'h0, 32'h0123_4561, 4'hF, h);
    rd_chk("ctrl_rw", 32'h0, 32'h0123_4561);
    axi_write(32'h0, 32'h89AB_CDE0, 4'h1, h);
    rd_chk("ctrl_strb", 32'h0, 32'h0123_45E0);

    // Offset binary pairing: 5,6 then 7,8
    axi_write(32'h0, 32'h0, 4'hF, h);
    axi_write(32'h0, 32'h1, 4'hF, h);
    fmt_model = 1'b0; chk_stream = 1'b1;
    if (((cyc + 1 - h) % 2) != 0) drive_tick('0);
    e0 = cyc + 1;
    drive_tick(14'd5); drive_tick(14'd6); drive_tick(14'd7); drive_tick(14'd8);
    chk("beat56_edge", cyc, e0 + 3);
    chk("beat56_valid", {31'd0, m_axis_tvalid}, 32'd1);
    chk("beat56", m_axis_tdata, 32'h0006_0005);
    drive_tick('0); drive_tick('0);
    chk("beat78", m_axis_tdata, 32'h0008_0007);
    chk_stream = 1'b0;
    axi_write(32'h0, 32'h0, 4'hF, h);
    repeat (4) tick();
    rd_chk("count_after_pairs", 32'h8, 32'(acc));

    // Two's complement format
    axi_write(32'h0, 32'h5, 4'hF, h);
    fmt_model = 1'b1; chk_stream = 1'b1;
    if (((cyc + 1 - h) % 2) != 0) drive_tick('0);
    drive_tick(14'h1FFF); drive_tick(14'h2000); drive_tick('0); drive_tick('0);
    chk("beat_fmt1", m_axis_tdata, 32'h0000_FFFF);
    axi_write(32'h0, 32'h0, 4'hF, h);
    repeat (4) tick();
    chk_stream = 1'b0;

    // Rail mismatch for one sample
    rd_chk("status_clean", 32'h4, 32'h0);
    data_in_p = 14'h0AAA; data_in_n = 14'h0AAA;
    tick();
    drive_tick('0); drive_tick('0);
    rd_chk("pair_err", 32'h4, 32'h2);
    axi_write(32'h4, 32'h2, 4'hF, h);
    rd_chk("pair_err_w1c", 32'h4, 32'h0);

    // Random stream against the model
    fmt_r = 1'($urandom);
    axi_write(32'h0, {29'd0, fmt_r, 2'b01}, 4'hF, h);
    fmt_model = fmt_r; chk_stream = 1'b1;
    a0 = acc;
    for (int i = 0; i < 200; i++) drive_tick(DW'($urandom));
    axi_write(32'h0, 32'h0, 4'hF, h);
    repeat (6) tick();
    chk_stream = 1'b0;
    chk("rand_beat_rate", {31'd0, (acc - a0) >= 95}, 32'd1);
    rd_chk("count_after_rand", 32'h8, 32'(acc));
    rd_chk("status_no_ovf", 32'h4, 32'h0);

    // Back-pressure: tready low for four cycles while a beat is held
    axi_write(32'h0, 32'h1, 4'hF, h);
    k = 0;
    while (!m_axis_tvalid && k < 20) begin drive_tick(DW'($urandom)); k++; end
    chk("ovf_first_valid", {31'd0, m_axis_tvalid}, 32'd1);
    held = m_axis_tdata;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_tick(DW'($urandom));
      chk("hold_valid", {31'd0, m_axis_tvalid}, 32'd1);
      chk("hold_data", m_axis_tdata, held);
    end
    m_axis_tready = 1'b1;
    repeat (6) drive_tick(DW'($urandom));
    axi_write(32'h0, 32'h0, 4'hF, h);
    repeat (6) tick();
    rd_chk("overflow", 32'h4, 32'h1);
    rd_chk("count_after_ovf", 32'h8, 32'(acc));

    // Last sample, with upper address bits set
    drive_tick(14'h1234); drive_tick(14'h1234);
    rd_chk("last_sample", 32'h1000_000C, 32'h0000_1234);

`ifdef TEST_PATTERN_EN
    axi_write(32'h0, 32'h89AB_CDE3, 4'hF, h);
    k = 0;
    while (cyc < h + 3 && k < 10) begin tick(); k++; end
    chk("ramp_edge", cyc, h + 3);
    chk("ramp_beat0", m_axis_tdata, 32'h0001_0000);
    tick(); tick();
    chk("ramp_beat1", m_axis_tdata, 32'h0003_0002);
    rd_chk("ctrl_tp", 32'h0, 32'h89AB_CDE3);
`else
    axi_write(32'h0, 32'h89AB_CDE2, 4'hF, h);
    rd_chk("ctrl_no_tp", 32'h0, 32'h89AB_CDE0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case any handshake never completes.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
